// File: rtl/cmsdk_apb4_eg_slave_if_ws.sv
// APB4 slave front end for the example register block.
// Terminates APB4 transfers, issues single-cycle read/write strobes to the
// register side, inserts WAIT_STATES extra access cycles and returns
// registered read data. Writes to the read-only ID region (0xFC0-0xFFF)
// are suppressed and answered with PSLVERR.
module cmsdk_apb4_eg_slave_if_ws #(
  parameter int ADDRWIDTH   = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic                 pclk,
  input  logic                 preset,
  // APB4 side
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [ADDRWIDTH-1:0] paddr,
  input  logic [31:0]          pwdata,
  input  logic [3:0]           pstrb,
  output logic [31:0]          prdata,
  output logic                 pready,
  output logic                 pslverr,
  // Register-block side
  output logic [ADDRWIDTH-1:0] addr,
  output logic                 read_en,
  output logic                 write_en,
  output logic [3:0]           byte_strobe,
  output logic [31:0]          wdata,
  input  logic [31:0]          rdata
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STROBE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Wait-state counter preload; WAIT_STATES is limited to 0..15.
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  // Clears the byte-lane bits of the captured address.
  localparam logic [ADDRWIDTH-1:0] WORD_MASK = {{(ADDRWIDTH-2){1'b1}}, 2'b00};

  // ID region is the top 64 bytes of the 4 KB window: paddr[11:6] all ones.
  localparam logic [5:0] ID_REGION = 6'h3F;

  state_t                 state;
  state_t                 state_nxt;
  logic                   pwrite_q;
  logic                   err_q;
  logic [3:0]             cnt;
  logic [ADDRWIDTH-1:0]   addr_q;
  logic [31:0]            wdata_q;
  logic [3:0]             strb_q;
  logic [31:0]            rdata_q;
  logic                   setup_accept;

  // A setup phase is only recognised while idle; penable high here is ignored.
  assign setup_accept = (state == ST_IDLE) && psel && !penable;

  // State register with synchronous reset.
  always_ff @(posedge pclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    if (preset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the transfer in the setup phase, register read data, count waits.
  always_ff @(posedge pclk) begin
    if (preset) begin
      pwrite_q <= 1'b0;
      err_q    <= 1'b0;
      cnt      <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      strb_q   <= 4'd0;
      rdata_q  <= 32'd0;
    end else begin
      if (setup_accept) begin
        pwrite_q <= pwrite;
        err_q    <= pwrite && (paddr[11:6] == ID_REGION);
        cnt      <= WAIT_INIT;
        addr_q   <= paddr & WORD_MASK;
        wdata_q  <= pwdata;
        // Byte strobes have no meaning for reads; present them as zero.
        strb_q   <= pwrite ? pstrb : 4'd0;
      end
      // Read data is sampled in the strobe cycle so later changes on rdata
      // cannot disturb the value returned with pready.
      if ((state == ST_STROBE) && !pwrite_q) begin
        rdata_q <= rdata;
      end
      if (state == ST_WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Next-state and output decode; a deselect during the access phase aborts.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value held (no latches).
    state_nxt = state;
    read_en   = 1'b0;
    write_en  = 1'b0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = 32'd0;

    unique case (state)
      ST_IDLE: begin
        if (setup_accept) begin
          state_nxt = ST_STROBE;
        end
      end

      ST_STROBE: begin
        read_en  = !pwrite_q;
        write_en = pwrite_q && !err_q;
        if (!psel) begin
          state_nxt = ST_IDLE;
        end else if (cnt != 4'd0) begin
          state_nxt = ST_WAIT;
        end else begin
          state_nxt = ST_RESP;
        end
      end

      ST_WAIT: begin
        if (!psel) begin
          state_nxt = ST_IDLE;
        end else if (cnt <= 4'd1) begin
          state_nxt = ST_RESP;
        end
      end

      ST_RESP: begin
        // An aborted transfer never sees pready.
        if (psel) begin
          pready  = 1'b1;
          pslverr = err_q;
          prdata  = pwrite_q ? 32'd0 : rdata_q;
        end
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Reset blanks every response and strobe in the same cycle.
    if (preset) begin
      read_en  = 1'b0;
      write_en = 1'b0;
      pready   = 1'b0;
      pslverr  = 1'b0;
      prdata   = 32'd0;
    end
  end

  // Register-side outputs come straight from the captured transfer.
  assign addr        = addr_q;
  assign wdata       = wdata_q;
  assign byte_strobe = strb_q;

endmodule

// File: tb/tb_cmsdk_apb4_eg_slave_if_ws.sv
// Self-checking bench for cmsdk_apb4_eg_slave_if_ws.
// Three instances (0, 3 and 5 wait states) share the APB bus with separate
// psel lines. Each has a small register-block stub; a transaction-level
// model of register contents supplies every expected value.
module tb_cmsdk_apb4_eg_slave_if_ws;

  localparam int NDUT = 3;

  function automatic int ws_of(input int i);
    case (i)
      0:       return 0;
      1:       return 3;
      default: return 5;
    endcase
  endfunction

  // Fixed peripheral/component ID words of the example register block.
  function automatic logic [31:0] id_value(input logic [11:0] a);
    case ({a[11:2], 2'b00})
      12'hFD0: return 32'h04;
      12'hFE0: return 32'h19;
      12'hFE4: return 32'hB8;
      12'hFE8: return 32'h1B;
      12'hFEC: return 32'h00;
      12'hFF0: return 32'h0D;
      12'hFF4: return 32'hF0;
      12'hFF8: return 32'h05;
      12'hFFC: return 32'hB1;
      default: return 32'h00;
    endcase
  endfunction

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel [NDUT];
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;

  logic [31:0] prdata      [NDUT];
  logic        pready      [NDUT];
  logic        pslverr     [NDUT];
  logic [11:0] addr        [NDUT];
  logic        read_en     [NDUT];
  logic        write_en    [NDUT];
  logic [3:0]  byte_strobe [NDUT];
  logic [31:0] wdata       [NDUT];
  logic [31:0] noise;

  logic [31:0] model_mem [NDUT][16];

  int n_checks = 0;
  int n_errors = 0;

  always #5 pclk = ~pclk;

  // Random junk on rdata whenever no read strobe is active.
  always @(negedge pclk) noise = $urandom;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    logic [31:0] mem [16];
    logic [31:0] look;
    logic [31:0] rdata;

    initial for (int i = 0; i < 16; i++) mem[i] = 32'd0;

    cmsdk_apb4_eg_slave_if_ws #(
      .ADDRWIDTH   (12),
      .WAIT_STATES (ws_of(g))
    ) u_dut (
      .pclk        (pclk),
      .preset      (preset),
      .psel        (psel[g]),
      .penable     (penable),
      .pwrite      (pwrite),
      .paddr       (paddr),
      .pwdata      (pwdata),
      .pstrb       (pstrb),
      .prdata      (prdata[g]),
      .pready      (pready[g]),
      .pslverr     (pslverr[g]),
      .addr        (addr[g]),
      .read_en     (read_en[g]),
      .write_en    (write_en[g]),
      .byte_strobe (byte_strobe[g]),
      .wdata       (wdata[g]),
      .rdata       (rdata)
    );

    // Register-block stub: 16 words at 0x000-0x03C plus the ID region.
    always @(posedge pclk) begin
      if (write_en[g] && (addr[g] < 12'h040)) begin
        for (int b = 0; b < 4; b++) begin
          if (byte_strobe[g][b]) mem[addr[g][5:2]][8*b +: 8] <= wdata[g][8*b +: 8];
        end
      end
    end

    always_comb begin
      look = 32'd0;
      if (addr[g] < 12'h040)       look = mem[addr[g][5:2]];
      else if (addr[g] >= 12'hFC0) look = id_value(addr[g]);
    end

    assign rdata = read_en[g] ? look : noise;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input int d, input logic [11:0] a);
    if (a < 12'h040)  return model_mem[d][a[5:2]];
    if (a >= 12'hFC0) return id_value(a);
    return 32'd0;
  endfunction

  task automatic check_all_zero(input int d);
    check("zero_prdata",   prdata[d],      32'd0);
    check("zero_pready",   pready[d],      32'd0);
    check("zero_pslverr",  pslverr[d],     32'd0);
    check("zero_read_en",  read_en[d],     32'd0);
    check("zero_write_en", write_en[d],    32'd0);
    check("zero_addr",     addr[d],        32'd0);
    check("zero_wdata",    wdata[d],       32'd0);
    check("zero_bstrb",    byte_strobe[d], 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge pclk);
      for (int i = 0; i < NDUT; i++) psel[i] = 1'b0;
      penable = 1'b0;
    end
  endtask

  // One complete APB transfer to instance d; starts at the next falling edge
  // and returns at the falling edge where pready is seen.
  task automatic apb_xfer(input int d, input bit wr, input logic [11:0] a,
                          input logic [31:0] wd, input logic [3:0] st);
    int          k;
    int          n_rd;
    int          n_wr;
    int          strobe_k;
    bit          done;
    bit          leak;
    bit          exp_err;
    logic [31:0] exp_rd;
    logic [11:0] exp_addr;

    exp_err  = wr && (a >= 12'hFC0);
    exp_rd   = wr ? 32'd0 : model_read(d, a);
    exp_addr = {a[11:2], 2'b00};

    @(negedge pclk);
    for (int i = 0; i < NDUT; i++) psel[i] = (i == d);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = wd;
    pstrb   = st;

    k = 0; n_rd = 0; n_wr = 0; strobe_k = 0; done = 0; leak = 0;
    while (!done && k < ws_of(d) + 6) begin
      @(negedge pclk);
      k++;
      penable = 1'b1;
      if (read_en[d] || write_en[d]) begin
        strobe_k = k;
        check("strobe_addr",  addr[d],        exp_addr);
        check("strobe_bstrb", byte_strobe[d], wr ? st : 4'd0);
      end
      if (read_en[d])  n_rd++;
      if (write_en[d]) begin
        n_wr++;
        check("strobe_wdata", wdata[d], wd);
      end
      if (pready[d]) begin
        done = 1;
        check("latency", 32'(k), 32'(2 + ws_of(d)));
        check("pslverr", pslverr[d], exp_err);
        check("prdata",  prdata[d],  exp_rd);
      end else if (prdata[d] !== 32'd0 || pslverr[d] !== 1'b0) begin
        leak = 1;
      end
    end
    check("pready_seen",   done, 1'b1);
    check("read_en_count", 32'(n_rd), wr ? 32'd0 : 32'd1);
    check("write_en_count", 32'(n_wr), (wr && !exp_err) ? 32'd1 : 32'd0);
    if (n_rd + n_wr > 0) check("strobe_cycle", 32'(strobe_k), 32'd1);
    check("resp_zero_when_not_ready", leak, 1'b0);

    if (wr && !exp_err && a < 12'h040) begin
      for (int b = 0; b < 4; b++) begin
        if (st[b]) model_mem[d][a[5:2]][8*b +: 8] = wd[8*b +: 8];
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int          n;
    int          d;
    bit          wr;
    logic [11:0] a;

    preset  = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 12'd0;
    pwdata  = 32'd0;
    pstrb   = 4'd0;
    for (int i = 0; i < NDUT; i++) psel[i] = 1'b0;
    for (int i = 0; i < NDUT; i++)
      for (int j = 0; j < 16; j++) model_mem[i][j] = 32'd0;

    repeat (3) @(negedge pclk);
    for (int i = 0; i < NDUT; i++) check_all_zero(i);
    preset = 1'b0;
    idle(2);

    // Zero wait states: write then read back.
    apb_xfer(0, 1, 12'h000, 32'hA5A5_1234, 4'hF);
    apb_xfer(0, 0, 12'h000, 32'h0, 4'hF);
    idle(1);

    // Three wait states with rdata churning after the strobe.
    apb_xfer(1, 1, 12'h004, 32'h1357_9BDF, 4'hF);
    idle(1);
    apb_xfer(1, 0, 12'h004, 32'h0, 4'h0);
    idle(1);

    // Write into the ID region is rejected; ID read still works.
    apb_xfer(0, 1, 12'hFE0, 32'hFFFF_FFFF, 4'hF);
    apb_xfer(0, 0, 12'hFE0, 32'h0, 4'h0);

    // Back-to-back partial write then read, no idle between them.
    apb_xfer(0, 1, 12'h008, 32'h1122_3344, 4'b0101);
    apb_xfer(0, 0, 12'h008, 32'h0, 4'h0);
    idle(1);

    // penable high without a setup phase is ignored.
    @(negedge pclk);
    psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h00C; pwdata = 32'hDEAD_BEEF; pstrb = 4'hF;
    n = 0;
    repeat (4) begin
      @(negedge pclk);
      if (pready[0] || read_en[0] || write_en[0]) n++;
    end
    check("penable_idle_ignored", 32'(n), 32'd0);
    idle(1);
    apb_xfer(0, 0, 12'h00C, 32'h0, 4'h0);
    idle(1);

    // Reset during WAIT on the five-wait-state instance.
    @(negedge pclk);
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h010; pstrb = 4'h0;
    repeat (3) begin
      @(negedge pclk);
      penable = 1'b1;
    end
    preset = 1'b1;
    #1;
    check("rst_wait_pready", pready[2], 1'b0);
    @(negedge pclk);
    check_all_zero(2);
    preset = 1'b0; psel[2] = 1'b0; penable = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge pclk);
      if (pready[2]) n++;
    end
    check("rst_wait_no_pready", 32'(n), 32'd0);
    apb_xfer(2, 1, 12'h010, 32'hCAFE_F00D, 4'hF);
    apb_xfer(2, 0, 12'h010, 32'h0, 4'h0);
    idle(1);

    // Reset in the strobe cycle blanks the write strobe immediately.
    @(negedge pclk);
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h014; pwdata = 32'h7777_7777; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    check("pre_rst_write_en", write_en[1], 1'b1);
    preset = 1'b1;
    #1;
    check("rst_strobe_write_en", write_en[1], 1'b0);
    @(negedge pclk);
    preset = 1'b0; psel[1] = 1'b0; penable = 1'b0;
    apb_xfer(1, 0, 12'h014, 32'h0, 4'h0);
    idle(1);

    // Deselect during WAIT aborts: no pready, no second strobe.
    @(negedge pclk);
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h00C; pstrb = 4'h0;
    n = 0;
    @(negedge pclk);
    penable = 1'b1;
    if (read_en[1]) n++;
    @(negedge pclk);
    if (read_en[1]) n++;
    psel[1] = 1'b0; penable = 1'b0;
    wr = 0;
    repeat (6) begin
      @(negedge pclk);
      if (read_en[1]) n++;
      if (pready[1]) wr = 1;
    end
    check("abort_read_en_count", 32'(n), 32'd1);
    check("abort_no_pready", wr, 1'b0);
    apb_xfer(1, 0, 12'h00C, 32'h0, 4'h0);

    // Randomised traffic across all instances.
    for (int t = 0; t < 80; t++) begin
      d  = $urandom_range(0, NDUT - 1);
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)
        a = 12'hFC0 | 12'($urandom_range(0, 15) * 4);
      else
        a = 12'($urandom_range(0, 15) * 4);
      a = a | 12'($urandom_range(0, 3));
      apb_xfer(d, wr, a, $urandom, 4'($urandom_range(0, 15)));
      n = $urandom_range(0, 2);
      if (n != 0) idle(n);
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
